tt_sweep_capture: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 32 +++
 rtl/tt_misr.sv | 47 ++++
 rtl/tt_sweep_capture.sv | 137 +++++++++++++
 tb/tb_tt_sweep_capture.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_pkg
// Brief    : Shared types, default constants and MISR step for tt_sweep_capture.
// Revision : 1.0
// ============================================================================
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int                 N_IN_D  = 5;
    localparam int                 N_OUT_D = 13;
    localparam int                 SIG_W_D = 16;
    localparam logic [SIG_W_D-1:0] POLY_D  = 16'h1021;
    localparam logic [SIG_W_D-1:0] SEED_D  = 16'hFFFF;

    // Shift left, fold in the polynomial when the MSB falls out, then xor the data.
    function automatic logic [SIG_W_D-1:0] misr_step(
        input logic [SIG_W_D-1:0] sig,
        input logic [SIG_W_D-1:0] data,
        input logic [SIG_W_D-1:0] poly
    );
        misr_step = {sig[SIG_W_D-2:0], 1'b0} ^ (sig[SIG_W_D-1] ? poly : '0) ^ data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_misr.sv
`default_nettype none
// ============================================================================
// Module   : tt_misr
// Brief    : Multiple-input signature register with seed load and step enable.
// Revision : 1.0
// ============================================================================
module tt_misr
    import tt_sweep_pkg::*;
#(
    parameter int               SIG_W = SIG_W_D,
    parameter logic [SIG_W-1:0] POLY  = POLY_D,
    parameter logic [SIG_W-1:0] SEED  = SEED_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    // The shared package helper is fixed at the default width; other widths use the same rule inline.
    generate
        if (SIG_W == SIG_W_D) begin : g_pkg_step
            assign w_next = misr_step(r_sig, data, POLY);
        end else begin : g_generic_step
            assign w_next = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= SEED;
        end else if (load) begin
            r_sig <= SEED;
        end else if (step) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_capture
// Brief    : Exhaustive truth-table sweep of a combinational CUT with record
//            streaming and MISR signature check.
// Revision : 1.0
// ============================================================================
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int               N_IN   = N_IN_D,
    parameter int               N_OUT  = N_OUT_D,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = SIG_W_D,
    parameter logic [SIG_W-1:0] POLY   = POLY_D,
    parameter logic [SIG_W-1:0] SEED   = SEED_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] exp_sig,
    output logic [N_IN-1:0]  cut_x,
    input  logic [N_OUT-1:0] cut_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  out_vec,
    output logic [N_OUT-1:0] out_resp,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             match
);

    localparam logic [3:0]      c_settle_last = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] c_last_vec    = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [N_IN-1:0]  r_vec;
    logic [3:0]       r_cnt;
    logic [N_OUT-1:0] r_resp;
    logic             r_match;

    logic             w_start_sweep;
    logic             w_capture;
    logic             w_accept;
    logic             w_sig_eq;

    always_comb begin
        w_state_next  = r_state;
        w_start_sweep = 1'b0;
        w_capture     = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_sweep = 1'b1;
                    w_state_next  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == c_settle_last) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = (r_vec == c_last_vec) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_resp  <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_sweep) begin
                r_vec   <= '0;
                r_cnt   <= '0;
                r_match <= 1'b0;
            end
            if (r_state == ST_DRIVE && !w_capture) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_capture) begin
                r_resp <= cut_f;
            end
            // The counter parks on the last vector instead of wrapping at sweep end.
            if (w_accept && r_vec != c_last_vec) begin
                r_vec <= r_vec + N_IN'(1);
                r_cnt <= '0;
            end
            if (r_state == ST_DONE) begin
                r_match <= w_sig_eq;
            end
        end
    end

    tt_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_sweep),
        .step (w_accept),
        .data (SIG_W'(r_resp)),
        .sig  (signature)
    );

    assign w_sig_eq  = (signature == exp_sig);
    assign cut_x     = r_vec;
    assign out_vec   = r_vec;
    assign out_resp  = r_resp;
    assign out_valid = (r_state == ST_EMIT);
    assign busy      = (r_state == ST_DRIVE) || (r_state == ST_EMIT);
    assign done      = (r_state == ST_DONE);
    // In the done cycle the comparison is shown live; afterwards the registered copy holds it.
    assign match     = (r_state == ST_DONE) ? w_sig_eq : r_match;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_sweep_capture
// Brief    : Self-checking bench: sweeps against a behavioural CUT and MISR model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tt_sweep_capture;

    localparam int NV = 32;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, out_ready, start3, out_ready3;
    logic [15:0] exp_sig, exp_sig3, signature, signature3;
    logic [4:0]  cut_x, cut_x3, out_vec, out_vec3, dly1, dly2;
    logic [12:0] cut_f, cut_f3, out_resp, out_resp3;
    logic        out_valid, busy, done, match;
    logic        out_valid3, busy3, done3, match3;

    int          cut_mode;
    logic [12:0] rand_tab [NV];
    int          checks = 0;
    int          failures = 0;
    logic [4:0]  rec_vec [$];
    logic [12:0] rec_resp [$];

    function automatic logic [12:0] cut_fn(input int m, input logic [4:0] x);
        case (m)
            0:       return {8'b0, x};
            1:       return 13'h1555 ^ {8'b0, x};
            default: return rand_tab[x];
        endcase
    endfunction

    // Signature model: multiply by two, reduce modulo the 17-bit polynomial, add the response.
    function automatic logic [15:0] model_sig(input int m);
        int s;
        s = 'hFFFF;
        for (int v = 0; v < NV; v++) begin
            s = s * 2;
            if (s >= 'h10000) s = (s - 'h10000) ^ 'h1021;
            s = s ^ int'(cut_fn(m, 5'(v)));
        end
        return 16'(s);
    endfunction

    assign cut_f  = (cut_mode == 0) ? {8'b0, cut_x} :
                    (cut_mode == 1) ? (13'h1555 ^ {8'b0, cut_x}) : rand_tab[cut_x];
    assign cut_f3 = (cut_mode == 0) ? {8'b0, dly2} :
                    (cut_mode == 1) ? (13'h1555 ^ {8'b0, dly2}) : rand_tab[dly2];

    always_ff @(posedge clk) begin
        dly1 <= cut_x3;
        dly2 <= dly1;
    end

    tt_sweep_capture #(.SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_sig(exp_sig),
        .cut_x(cut_x), .cut_f(cut_f), .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_resp(out_resp), .busy(busy), .done(done),
        .signature(signature), .match(match)
    );

    tt_sweep_capture #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .exp_sig(exp_sig3),
        .cut_x(cut_x3), .cut_f(cut_f3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_vec(out_vec3), .out_resp(out_resp3), .busy(busy3), .done(done3),
        .signature(signature3), .match(match3)
    );

    // Runs one sweep on dut from an IDLE cycle; returns positioned in the cycle after DONE.
    task automatic run_sweep(input int ready_pct, input bit extra_starts,
                             output int done_cycle, output logic [15:0] sig_done,
                             output logic match_after, output logic busy_after,
                             output int stab_err);
        logic        pv;
        logic [4:0]  pvec;
        logic [12:0] presp;
        bit          pulsed5;
        int          t;
        rec_vec.delete();
        rec_resp.delete();
        done_cycle = -1; stab_err = 0; pv = 1'b0; pulsed5 = 1'b0;
        sig_done = '0; pvec = '0; presp = '0; t = 0;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (t < 3000) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (pv && (!out_valid || out_vec !== pvec || out_resp !== presp)) stab_err++;
            if (out_valid && cut_x !== out_vec) stab_err++;
            if (out_valid && out_ready) begin
                rec_vec.push_back(out_vec);
                rec_resp.push_back(out_resp);
            end
            pv = out_valid && !out_ready; pvec = out_vec; presp = out_resp;
            start = 1'b0;
            if (extra_starts && !pulsed5 && out_valid && out_vec == 5'd5) begin
                start = 1'b1; pulsed5 = 1'b1;
            end
            if (done) begin
                done_cycle = t; sig_done = signature;
                if (extra_starts) start = 1'b1;
                break;
            end
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        match_after = match; busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start3 = 1'b0; out_ready = 1'b1; out_ready3 = 1'b1;
        exp_sig = 16'h0; exp_sig3 = 16'h0; cut_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cut_x !== 5'd0) begin failures++; $display("FAIL reset_cut_x got=%h exp=0", cut_x); end
        checks++; if (out_vec !== 5'd0) begin failures++; $display("FAIL reset_out_vec got=%h exp=0", out_vec); end
        checks++; if (out_resp !== 13'd0) begin failures++; $display("FAIL reset_out_resp got=%h exp=0", out_resp); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", match); end
        checks++; if (signature !== 16'hFFFF) begin failures++; $display("FAIL reset_signature got=%h exp=ffff", signature); end
        checks++; if (signature3 !== 16'hFFFF) begin failures++; $display("FAIL reset_signature3 got=%h exp=ffff", signature3); end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_beats_start busy got=%b exp=0", busy); end
    endtask

    task automatic test_loopback();
        int dc, se; logic [15:0] sg; logic mt, bz; logic [15:0] em;
        cut_mode = 0; em = model_sig(0); exp_sig = em;
        run_sweep(100, 1'b0, dc, sg, mt, bz, se);
        checks++; if (rec_vec.size() != NV) begin failures++; $display("FAIL loop_count got=%0d exp=%0d", rec_vec.size(), NV); end
        for (int i = 0; i < rec_vec.size(); i++) begin
            checks++;
            if (rec_vec[i] !== 5'(i) || rec_resp[i] !== cut_fn(0, 5'(i))) begin
                failures++; $display("FAIL loop_rec%0d got=%h/%h exp=%h/%h", i, rec_vec[i], rec_resp[i], 5'(i), cut_fn(0, 5'(i)));
            end
        end
        checks++; if (dc != 64) begin failures++; $display("FAIL loop_latency got=%0d exp=64", dc); end
        checks++; if (bz !== 1'b0) begin failures++; $display("FAIL loop_busy_after got=%b exp=0", bz); end
        checks++; if (sg !== em) begin failures++; $display("FAIL loop_sig got=%h exp=%h", sg, em); end
        checks++; if (mt !== 1'b1) begin failures++; $display("FAIL loop_match got=%b exp=1", mt); end
    endtask

    task automatic test_signature();
        int dc, se; logic [15:0] sg; logic mt, bz; logic [15:0] em;
        cut_mode = 1; em = model_sig(1); exp_sig = em;
        run_sweep(100, 1'b0, dc, sg, mt, bz, se);
        checks++; if (sg !== em) begin failures++; $display("FAIL sig_value got=%h exp=%h", sg, em); end
        checks++; if (mt !== 1'b1) begin failures++; $display("FAIL sig_match got=%b exp=1", mt); end
        // Restart in the IDLE cycle straight after DONE.
        exp_sig = em ^ 16'h0001;
        run_sweep(100, 1'b0, dc, sg, mt, bz, se);
        checks++; if (dc != 64) begin failures++; $display("FAIL sig_b2b_latency got=%0d exp=64", dc); end
        checks++; if (sg !== em) begin failures++; $display("FAIL sig_b2b_value got=%h exp=%h", sg, em); end
        checks++; if (mt !== 1'b0) begin failures++; $display("FAIL sig_mismatch got=%b exp=0", mt); end
    endtask

    task automatic test_backpressure();
        int dc, se; logic [15:0] sg_a, sg_b; logic mt, bz; logic [15:0] em;
        cut_mode = 0;
        for (int i = 0; i < NV; i++) rand_tab[i] = 13'($urandom);
        cut_mode = 2; em = model_sig(2); exp_sig = em;
        run_sweep(100, 1'b0, dc, sg_a, mt, bz, se);
        run_sweep(30, 1'b0, dc, sg_b, mt, bz, se);
        checks++; if (rec_vec.size() != NV) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", rec_vec.size(), NV); end
        for (int i = 0; i < rec_vec.size(); i++) begin
            checks++;
            if (rec_vec[i] !== 5'(i) || rec_resp[i] !== cut_fn(2, 5'(i))) begin
                failures++; $display("FAIL bp_rec%0d got=%h/%h exp=%h/%h", i, rec_vec[i], rec_resp[i], 5'(i), cut_fn(2, 5'(i)));
            end
        end
        checks++; if (dc < 64) begin failures++; $display("FAIL bp_done got=%0d exp>=64", dc); end
        checks++; if (se != 0) begin failures++; $display("FAIL bp_stability errors=%0d exp=0", se); end
        checks++; if (sg_a !== em) begin failures++; $display("FAIL bp_sig_ready got=%h exp=%h", sg_a, em); end
        checks++; if (sg_b !== em) begin failures++; $display("FAIL bp_sig_random got=%h exp=%h", sg_b, em); end
        checks++; if (mt !== 1'b1) begin failures++; $display("FAIL bp_match got=%b exp=1", mt); end
    endtask

    task automatic test_settle3();
        int t, dc; logic [15:0] sg; logic [15:0] em;
        cut_mode = 2; em = model_sig(2); exp_sig3 = em;
        rec_vec.delete(); rec_resp.delete();
        t = 0; dc = -1; sg = '0;
        start3 = 1'b1; out_ready3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        while (t < 1000) begin
            if (out_valid3) begin rec_vec.push_back(out_vec3); rec_resp.push_back(out_resp3); end
            if (done3) begin dc = t; sg = signature3; break; end
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        checks++; if (rec_vec.size() != NV) begin failures++; $display("FAIL s3_count got=%0d exp=%0d", rec_vec.size(), NV); end
        for (int i = 0; i < rec_vec.size(); i++) begin
            checks++;
            if (rec_vec[i] !== 5'(i) || rec_resp[i] !== cut_fn(2, 5'(i))) begin
                failures++; $display("FAIL s3_rec%0d got=%h/%h exp=%h/%h", i, rec_vec[i], rec_resp[i], 5'(i), cut_fn(2, 5'(i)));
            end
        end
        checks++; if (dc != 128) begin failures++; $display("FAIL s3_latency got=%0d exp=128", dc); end
        checks++; if (sg !== em) begin failures++; $display("FAIL s3_sig got=%h exp=%h", sg, em); end
        checks++; if (match3 !== 1'b1) begin failures++; $display("FAIL s3_match got=%b exp=1", match3); end
    endtask

    task automatic test_reset_midrun();
        int n, dc, se; bit got10, seen_done; logic [15:0] sg; logic mt, bz; logic [15:0] em;
        cut_mode = 0; em = model_sig(0); exp_sig = em;
        n = 0; got10 = 0; seen_done = 0;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got10 && n < 500) begin
            if (done) seen_done = 1;
            if (out_valid && out_vec == 5'd10) got10 = 1;
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (!got10) begin failures++; $display("FAIL mid_reach10 got=0 exp=1"); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (signature !== 16'hFFFF) begin failures++; $display("FAIL mid_sig got=%h exp=ffff", signature); end
        checks++; if (done !== 1'b0 || seen_done) begin failures++; $display("FAIL mid_no_done got=%b/%0d exp=0/0", done, seen_done); end
        rst = 1'b0;
        @(posedge clk); #1;
        run_sweep(100, 1'b0, dc, sg, mt, bz, se);
        checks++; if (rec_vec.size() != NV) begin failures++; $display("FAIL mid_fresh_count got=%0d exp=%0d", rec_vec.size(), NV); end
        checks++; if (dc != 64) begin failures++; $display("FAIL mid_fresh_latency got=%0d exp=64", dc); end
        checks++; if (mt !== 1'b1) begin failures++; $display("FAIL mid_fresh_match got=%b exp=1", mt); end
    endtask

    task automatic test_start_ignored();
        int dc, se; logic [15:0] sg; logic mt, bz; logic [15:0] em;
        cut_mode = 0; em = model_sig(0); exp_sig = em;
        run_sweep(100, 1'b1, dc, sg, mt, bz, se);
        checks++; if (rec_vec.size() != NV) begin failures++; $display("FAIL ign_count got=%0d exp=%0d", rec_vec.size(), NV); end
        for (int i = 0; i < rec_vec.size(); i++) begin
            checks++;
            if (rec_vec[i] !== 5'(i)) begin failures++; $display("FAIL ign_rec%0d got=%h exp=%h", i, rec_vec[i], 5'(i)); end
        end
        checks++; if (dc != 64) begin failures++; $display("FAIL ign_latency got=%0d exp=64", dc); end
        checks++; if (bz !== 1'b0) begin failures++; $display("FAIL ign_busy_after_done got=%b exp=0", bz); end
        checks++; if (sg !== em) begin failures++; $display("FAIL ign_sig got=%h exp=%h", sg, em); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy_later got=%b exp=0", busy); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0; out_ready = 1'b1; out_ready3 = 1'b1;
        exp_sig = '0; exp_sig3 = '0; cut_mode = 0;
        for (int i = 0; i < NV; i++) rand_tab[i] = '0;
        #1;
        test_reset();
        test_loopback();
        test_signature();
        test_backpressure();
        test_settle3();
        test_reset_midrun();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
